mips_multicycle_ctrl: RTL and testbench

Main control unit for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback cycles. Drives every datapath mux and enable, including the 4-bit ALU operation code. Consumes the ALU `zero` flag to resolve `beq`.

---
 rtl/mips_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM for the multicycle MIPS datapath. Each instruction is
//   sequenced through fetch, decode, then class-specific execute, memory and
//   writeback states. All datapath selects and enables are decoded from the
//   current state. There are three exceptions: pc_en in BRANCH follows the ALU
//   zero flag combinationally, and the ALU op and ALU A-source in EXEC come
//   from funct.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   opcode, funct  IR[31:26] / IR[5:0], held from DECODE until the next FETCH
//   zero           ALU zero flag (combinational, used in BRANCH only)
//   pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
//   reg_write      datapath enables / 1-bit selects
//   alu_src_a      0 PC, 1 A, 2 B (shift source)
//   alu_src_b      0 B, 1 const 4, 2 sext imm, 3 sext imm << 2
//   alu_control    0 AND, 1 OR, 2 SLL, 4 ADD, 6 SUB, 7 SLT, 12 NOR
//   pc_source      0 ALU result, 1 ALUOut, 2 jump target
//   illegal_op     sticky flag, set on an unsupported opcode/funct
//   state          current state encoding (debug)
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  state_t state_q, state_d;
  logic   is_lw_q;      // lw vs sw, captured in DECODE for the MEMADR branch
  logic   illegal_q;

  // R-type funct decode: ALU op, A-source, and whether the funct is supported.
  logic       funct_ok;
  logic [3:0] exec_alu;
  logic [1:0] exec_src_a;

  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path through the case statements can leave it unassigned (latch).
  always_comb begin
    funct_ok   = 1'b1;
    exec_alu   = ALU_AND;
    exec_src_a = 2'd1;
    case (funct)
      6'b100000: exec_alu = ALU_ADD;
      6'b100010: exec_alu = ALU_SUB;
      6'b100100: exec_alu = ALU_AND;
      6'b100101: exec_alu = ALU_OR;
      6'b101010: exec_alu = ALU_SLT;
      6'b100111: exec_alu = ALU_NOR;
      6'b000000: begin
        exec_alu   = ALU_SLL;
        exec_src_a = 2'd2;        // shifts take the shifted operand from B
      end
      default:   funct_ok = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      is_lw_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_lw_q <= (opcode == OP_LW);
        // Sticky: only reset clears it.
        if (state_d == S_FETCH)
          illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_en       = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_control = ALU_AND;
    pc_source   = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        ir_write    = 1'b1;
        alu_src_b   = 2'd1;
        alu_control = ALU_ADD;
        pc_en       = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        alu_src_b   = 2'd3;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 2'd1;
        alu_src_b   = 2'd2;
        alu_control = ALU_ADD;
        state_d     = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a   = exec_src_a;
        alu_control = exec_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'd1;
        alu_control = ALU_SUB;
        pc_source   = 2'd1;
        pc_en       = zero;
      end
      S_ADDIEX: begin
        alu_src_a   = 2'd1;
        alu_src_b   = 2'd2;
        alu_control = ALU_ADD;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_source = 2'd2;
        pc_en     = 1'b1;
      end
      default: ;                  // codes 12-15: all outputs 0, back to FETCH
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: a directed table of
// instructions, hand-written reset corner cases, then randomized instructions
// checked cycle by cycle against a per-instruction expected-output model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, pc_source;
  logic [3:0] alu_control, state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_source(pc_source),
    .illegal_op(illegal_op), .state(state)
  );

  // One snapshot of every output except illegal_op.
  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write;
    logic [1:0] src_a, src_b;
    logic [3:0] alu;
    logic [1:0] pc_src;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         zm;       // 0/1 fixed zero, 2 random per cycle
    int         cyc;      // expected cycles FETCH..last state
    bit         is_r;     // legal R-type: check EXEC decode
    logic [3:0] ex_alu;
    logic [1:0] ex_a;
    bit         ill;      // illegal_op after the instruction
  } vec_t;

  int  alu_of [logic [5:0]];   // supported funct -> ALU op
  bit  ill_m;                  // model of the sticky flag

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic out_t actual();
    out_t o;
    o.st = state; o.pc_en = pc_en; o.i_or_d = i_or_d; o.mem_read = mem_read;
    o.mem_write = mem_write; o.ir_write = ir_write; o.mem_to_reg = mem_to_reg;
    o.reg_dst = reg_dst; o.reg_write = reg_write; o.src_a = alu_src_a;
    o.src_b = alu_src_b; o.alu = alu_control; o.pc_src = pc_source;
    return o;
  endfunction

  // flags = {pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write}
  function automatic out_t mkv(input int st, input logic [7:0] flags, input int a,
                               input int b, input int alu, input int ps);
    out_t o;
    o.st = 4'(st);
    {o.pc_en, o.i_or_d, o.mem_read, o.mem_write,
     o.ir_write, o.mem_to_reg, o.reg_dst, o.reg_write} = flags;
    o.src_a = 2'(a); o.src_b = 2'(b); o.alu = 4'(alu); o.pc_src = 2'(ps);
    return o;
  endfunction

  function automatic out_t v_fetch();
    return mkv(0, 8'b1010_1000, 0, 1, 4, 0);
  endfunction

  // Expected per-cycle outputs for one instruction, straight from the
  // instruction-class step lists. BRANCH pc_en is filled in at run time.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                output out_t q[$], output bit legal);
    out_t ma;
    q = {};
    q.push_back(v_fetch());
    q.push_back(mkv(1, 8'b0, 0, 3, 4, 0));
    ma = mkv(2, 8'b0, 1, 2, 4, 0);
    legal = 1'b1;
    case (op)
      6'b100011: begin
        q.push_back(ma);
        q.push_back(mkv(3, 8'b0110_0000, 0, 0, 0, 0));
        q.push_back(mkv(4, 8'b0000_0101, 0, 0, 0, 0));
      end
      6'b101011: begin
        q.push_back(ma);
        q.push_back(mkv(5, 8'b0101_0000, 0, 0, 0, 0));
      end
      6'b000000: begin
        if (alu_of.exists(fn)) begin
          q.push_back(mkv(6, 8'b0, (fn == 6'b000000) ? 2 : 1, 0, alu_of[fn], 0));
          q.push_back(mkv(7, 8'b0000_0011, 0, 0, 0, 0));
        end else legal = 1'b0;
      end
      6'b000100: q.push_back(mkv(8, 8'b0, 1, 0, 6, 1));
      6'b001000: begin
        q.push_back(mkv(9, 8'b0, 1, 2, 4, 0));
        q.push_back(mkv(10, 8'b0000_0001, 0, 0, 0, 0));
      end
      6'b000010: q.push_back(mkv(11, 8'b1000_0000, 0, 0, 0, 2));
      default:   legal = 1'b0;
    endcase
  endfunction

  // Runs one instruction starting in a FETCH cycle (called at posedge+1).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zm,
                           output int n_obs, output logic [3:0] ex_alu,
                           output logic [1:0] ex_a);
    out_t q[$];
    out_t e;
    bit   legal;
    build(op, fn, q, legal);
    opcode = op;
    funct  = fn;
    n_obs  = 0;
    ex_alu = 4'hf;
    ex_a   = 2'd3;
    for (int i = 0; i < q.size(); i++) begin
      zero = (zm == 2) ? 1'($urandom_range(0, 1)) : 1'(zm);
      @(negedge clk);
      e = q[i];
      if (e.st == 4'd8) e.pc_en = zero;
      check("outputs", 32'(actual()), 32'(e));
      check("illegal_op", 32'(illegal_op), 32'(ill_m));
      if (state == 4'd6) begin
        ex_alu = alu_control;
        ex_a   = alu_src_a;
      end
      if (i > 0 && state == 4'd0 && n_obs == 0) n_obs = i;
      if (q[i].st == 4'd1 && !legal) ill_m = 1'b1;
      @(posedge clk);
      #1;
    end
    if (n_obs == 0) n_obs = (state == 4'd0) ? q.size() : 99;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ill_m = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    int         n_obs;
    logic [3:0] ex_alu;
    logic [1:0] ex_a;
    logic [5:0] ops [6];

    alu_of[6'b100000] = 4;  alu_of[6'b100010] = 6;  alu_of[6'b100100] = 0;
    alu_of[6'b100101] = 1;  alu_of[6'b101010] = 7;  alu_of[6'b100111] = 12;
    alu_of[6'b000000] = 2;

    tbl[0]  = '{6'b100011, 6'b000000, 0, 5, 1'b0, 4'd0,  2'd0, 1'b0}; // lw
    tbl[1]  = '{6'b101011, 6'b000000, 0, 4, 1'b0, 4'd0,  2'd0, 1'b0}; // sw
    tbl[2]  = '{6'b000000, 6'b100010, 0, 4, 1'b1, 4'd6,  2'd1, 1'b0}; // sub
    tbl[3]  = '{6'b000000, 6'b000000, 0, 4, 1'b1, 4'd2,  2'd2, 1'b0}; // sll
    tbl[4]  = '{6'b000000, 6'b100111, 0, 4, 1'b1, 4'd12, 2'd1, 1'b0}; // nor
    tbl[5]  = '{6'b000000, 6'b100000, 0, 4, 1'b1, 4'd4,  2'd1, 1'b0}; // add
    tbl[6]  = '{6'b000000, 6'b100100, 0, 4, 1'b1, 4'd0,  2'd1, 1'b0}; // and
    tbl[7]  = '{6'b000000, 6'b100101, 0, 4, 1'b1, 4'd1,  2'd1, 1'b0}; // or
    tbl[8]  = '{6'b000000, 6'b101010, 0, 4, 1'b1, 4'd7,  2'd1, 1'b0}; // slt
    tbl[9]  = '{6'b001000, 6'b000000, 0, 4, 1'b0, 4'd0,  2'd0, 1'b0}; // addi
    tbl[10] = '{6'b000100, 6'b000000, 1, 3, 1'b0, 4'd0,  2'd0, 1'b0}; // beq taken
    tbl[11] = '{6'b000100, 6'b000000, 0, 3, 1'b0, 4'd0,  2'd0, 1'b0}; // beq not taken
    tbl[12] = '{6'b111111, 6'b000000, 0, 2, 1'b0, 4'd0,  2'd0, 1'b1}; // illegal opcode
    tbl[13] = '{6'b000010, 6'b000000, 0, 3, 1'b0, 4'd0,  2'd0, 1'b1}; // j, flag stays
    tbl[14] = '{6'b000000, 6'b000001, 0, 2, 1'b0, 4'd0,  2'd0, 1'b1}; // bad funct

    opcode = 6'b0; funct = 6'b0; zero = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_outputs", 32'(actual()), 32'(v_fetch()));
    check("reset_illegal", 32'(illegal_op), 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].zm, n_obs, ex_alu, ex_a);
      check($sformatf("cycles[%0d]", i), 32'(n_obs), 32'(tbl[i].cyc));
      check($sformatf("illegal_after[%0d]", i), 32'(illegal_op), 32'(tbl[i].ill));
      if (tbl[i].is_r) begin
        check($sformatf("exec_alu[%0d]", i), 32'(ex_alu), 32'(tbl[i].ex_alu));
        check($sformatf("exec_src_a[%0d]", i), 32'(ex_a), 32'(tbl[i].ex_a));
      end
    end

    // Reset mid-lw in MEMRD with the sticky flag set: abandon, clear flag,
    // no MEMWB write afterwards.
    opcode = 6'b100011;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_reset_in_memrd", 32'(state), 32'd3);
    check("mid_reset_flag_before", 32'(illegal_op), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ill_m = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", 32'(actual()), 32'(v_fetch()));
    check("mid_reset_illegal", 32'(illegal_op), 32'd0);
    check("mid_reset_no_wb", 32'(reg_write), 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Randomized instructions against the model
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    for (int k = 0; k < 300; k++) begin
      logic [5:0] op, fn;
      logic [5:0] fns [7];
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
              6'b101010, 6'b100111, 6'b000000};
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 5)] : 6'($urandom);
      fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 6)] : 6'($urandom);
      run_instr(op, fn, 2, n_obs, ex_alu, ex_a);
      if (k == 150) do_reset();
    end
    check("final_state", 32'(state), 32'd0);
    check("final_illegal", 32'(illegal_op), 32'(ill_m));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
